sched_acc_select: RTL and testbench
===================================

SCHED_ACC_SELECT -- requirements
Module: sched_acc_select

Interface
REQ-001 SHALL have parameter MAX_ACCS, 16, total accelerator instances; ACC_BITS = clog2(MAX_ACCS).
REQ-002 SHALL have parameter MAX_ACC_TYPES, 16, scheduling table depth; ACC_TYPE_BITS = clog2(MAX_ACC_TYPES).
REQ-003 SHALL have parameter TASKTYPE_BITS, 40, task type width.
REQ-004 SHALL have parameter SCHED_DATA_BITS, 48, table word width; layout [TASKTYPE_BITS-1:0] task type, [40+ACC_BITS-1:40] instances-1, [44+ACC_BITS-1:44] first acc id.
REQ-005 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have table_valid  input  1  scheduling table fully written by parser.
REQ-008 SHALL have num_acc_types  input  ACC_TYPE_BITS+1  valid table entries, 0..MAX_ACC_TYPES.
REQ-009 SHALL have req_valid / req_ready  input / output  1 / 1  task request handshake.
REQ-010 SHALL have req_task_type  input  TASKTYPE_BITS  requested task type.
REQ-011 SHALL have sched_addr  output  ACC_TYPE_BITS  table read address (port B).
REQ-012 SHALL have sched_en  output  1  table read enable; read data valid one cycle after en.
REQ-013 SHALL have sched_dout  input  SCHED_DATA_BITS  table read data.
REQ-014 SHALL have resp_valid / resp_ready  output / input  1 / 1  response handshake.
REQ-015 SHALL have resp_found  output  1  task type present in table.
REQ-016 SHALL have resp_acc_id  output  ACC_BITS  selected accelerator id; 0 when not found.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CHECK, RESP.
REQ-018 IDLE: req_ready = table_valid; on req_valid && req_ready capture req_task_type, clear entry index; go ISSUE, or RESP with resp_found=0 if num_acc_types==0.
REQ-019 ISSUE: sched_en=1, sched_addr=entry index; go CHECK.
REQ-020 CHECK: compare sched_dout task-type field with captured type (full TASKTYPE_BITS equality).
REQ-021 CHECK match: resp_found=1, resp_acc_id = first_acc + rr[index] (mod 2^ACC_BITS); go RESP.
REQ-022 CHECK match: rr[index] <= 0 if rr[index] == count field, else rr[index]+1 (round robin over instances).
REQ-023 CHECK miss: if index+1 == num_acc_types go RESP with resp_found=0, resp_acc_id=0; else index+1, go ISSUE.
REQ-024 RESP: resp_valid=1, resp fields stable until resp_ready; on resp_valid && resp_ready go IDLE.
REQ-025 Latency: request accepted cycle T, match at entry k -> resp_valid first high cycle T+3+2k; empty table -> T+1.
REQ-026 sched_en SHALL be 0 outside ISSUE; req_ready SHALL be 0 outside IDLE.
REQ-027 Exactly one request in flight; no new accept until response handshake completes.
REQ-028 Duplicate table entries: first (lowest index) match wins.
REQ-029 rr array (MAX_ACC_TYPES x ACC_BITS) SHALL clear to 0 whenever table_valid is 0.
REQ-030 table_valid falling mid-lookup SHALL NOT abort the lookup in progress.

Reset
REQ-031 rstn low at a clock edge: state IDLE, all rr 0, resp_valid 0, resp_found 0, resp_acc_id 0, sched_en 0, sched_addr 0, index 0.
REQ-032 Reset asserted mid-lookup or during RESP SHALL drop the pending request without a response.

Verification
REQ-033 Table {0:type 0x11, first 0, count 1; 1:type 0x22, first 2, count 2}, num=2; four requests 0x22 -> acc ids 2,3,4,2, found=1, first response at T+5.
REQ-034 Request 0x33 with same table -> resp_found=0, resp_acc_id=0 at T+5; rr unchanged.
REQ-035 num_acc_types=0, request 0x11 -> resp_found=0 at T+1, sched_en never asserted.
REQ-036 Hold resp_ready=0 for 5 cycles -> resp fields stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-037 Pulse rstn low during CHECK -> no response, next request 0x22 returns acc id 2; toggle table_valid low -> rr cleared, 0x11 returns 0.

Source files
------------

// File: rtl/sched_acc_select.sv
// ---------------------------------------------------------------------------
// sched_acc_select
//
// Looks up an incoming task type in the scheduling table and picks the
// accelerator instance that should run it. The table is walked one entry at
// a time through a synchronous read port with one cycle of read latency. On
// a hit, the per-entry round-robin pointer chooses among that entry's
// instances and then advances. On a miss, or when the table is empty, the
// module answers "not found".
//
// Ports:
//   clk, rstn          clock (rising edge), synchronous active-low reset
//   table_valid        scheduling table fully written; also gates rr state
//   num_acc_types      number of valid table entries (0..MAX_ACC_TYPES)
//   req_valid/ready    task request handshake, req_task_type is the key
//   sched_addr/en      table read port; data returns on sched_dout next cycle
//   sched_dout         table word {first acc id, instances-1, task type}
//   resp_valid/ready   response handshake
//   resp_found         task type was present in the table
//   resp_acc_id        selected accelerator id (0 when not found)
// ---------------------------------------------------------------------------
module sched_acc_select #(
   parameter int MAX_ACCS        = 16,
   parameter int MAX_ACC_TYPES   = 16,
   parameter int TASKTYPE_BITS   = 40,
   parameter int SCHED_DATA_BITS = 48,
   localparam int ACC_BITS       = $clog2(MAX_ACCS),
   localparam int ACC_TYPE_BITS  = $clog2(MAX_ACC_TYPES)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       table_valid,
   input  logic [ACC_TYPE_BITS:0]     num_acc_types,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [TASKTYPE_BITS-1:0]   req_task_type,
   output logic [ACC_TYPE_BITS-1:0]   sched_addr,
   output logic                       sched_en,
   input  logic [SCHED_DATA_BITS-1:0] sched_dout,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic                       resp_found,
   output logic [ACC_BITS-1:0]        resp_acc_id
);

   // Field positions inside a table word.
   localparam int CNT_LSB   = 40;
   localparam int FIRST_LSB = 44;

   localparam logic [ACC_TYPE_BITS:0] ENTRY_ONE = 1;
   localparam logic [ACC_BITS-1:0]    RR_ONE    = 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CHECK,
      RESP
   } state_t;

   state_t                     state_q, state_d;
   logic [ACC_TYPE_BITS-1:0]   index_q, index_d;
   logic [TASKTYPE_BITS-1:0]   type_q, type_d;
   logic                       found_q, found_d;
   logic [ACC_BITS-1:0]        acc_id_q, acc_id_d;
   logic [ACC_BITS-1:0]        rr_q [MAX_ACC_TYPES];
   logic [ACC_BITS-1:0]        rr_d [MAX_ACC_TYPES];

   logic [TASKTYPE_BITS-1:0]   dout_type;
   logic [ACC_BITS-1:0]        dout_cnt;
   logic [ACC_BITS-1:0]        dout_first;
   logic                       last_entry;

   assign dout_type  = sched_dout[TASKTYPE_BITS-1:0];
   assign dout_cnt   = sched_dout[CNT_LSB +: ACC_BITS];
   assign dout_first = sched_dout[FIRST_LSB +: ACC_BITS];

   // Widened by one bit so a full table (index 15, count 16) compares cleanly.
   assign last_entry = (({1'b0, index_q} + ENTRY_ONE) == num_acc_types);

   assign sched_addr  = index_q;
   assign resp_found  = found_q;
   assign resp_acc_id = acc_id_q;

   // Next-state and output decode for the lookup walk. Outputs that only
   // make sense in one state (ready, read enable, response valid) are
   // defaulted low and raised in that state alone.
   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      type_d     = type_q;
      found_d    = found_q;
      acc_id_d   = acc_id_q;
      rr_d       = rr_q;
      req_ready  = 1'b0;
      sched_en   = 1'b0;
      resp_valid = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = table_valid;
            if (req_valid && table_valid) begin
               type_d  = req_task_type;
               index_d = '0;
               if (num_acc_types == '0) begin
                  found_d  = 1'b0;
                  acc_id_d = '0;
                  state_d  = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            sched_en = 1'b1;
            state_d  = CHECK;
         end
         CHECK: begin
            // The lowest matching index wins because the walk stops at the
            // first hit.
            if (dout_type == type_q) begin
               found_d  = 1'b1;
               acc_id_d = dout_first + rr_q[index_q];
               if (rr_q[index_q] == dout_cnt) begin
                  rr_d[index_q] = '0;
               end else begin
                  rr_d[index_q] = rr_q[index_q] + RR_ONE;
               end
               state_d = RESP;
            end else if (last_entry) begin
               found_d  = 1'b0;
               acc_id_d = '0;
               state_d  = RESP;
            end else begin
               index_d = index_q + ENTRY_ONE[ACC_TYPE_BITS-1:0];
               state_d = ISSUE;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Round-robin history is meaningless once the table is being
      // rewritten. Clearing it takes priority over a hit in the same cycle,
      // but the lookup itself still finishes.
      if (!table_valid) begin
         for (int i = 0; i < MAX_ACC_TYPES; i++) begin
            rr_d[i] = '0;
         end
      end
   end

   // State registers. Reset drops any request in flight without answering it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         index_q  <= '0;
         type_q   <= '0;
         found_q  <= 1'b0;
         acc_id_q <= '0;
         for (int i = 0; i < MAX_ACC_TYPES; i++) begin
            rr_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         type_q   <= type_d;
         found_q  <= found_d;
         acc_id_q <= acc_id_d;
         rr_q     <= rr_d;
      end
   end

endmodule

// File: tb/tb_sched_acc_select.sv
// ---------------------------------------------------------------------------
// tb_sched_acc_select
//
// Drives task requests into sched_acc_select and emulates the scheduling
// table read port with one cycle of latency. A transaction-level model
// predicts each answer when the request is accepted: a linear search for
// the lowest matching entry, a per-entry round-robin counter, and the
// response cycle. A single negedge process compares the DUT against that
// prediction every cycle.
// ---------------------------------------------------------------------------
module tb_sched_acc_select;

   localparam int TT = 40;
   localparam int DW = 48;
   localparam int AB = 4;
   localparam int TB = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          table_valid = 1'b0;
   logic [TB:0]   num_acc_types = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [TT-1:0] req_task_type = '0;
   logic [TB-1:0] sched_addr;
   logic          sched_en;
   logic [DW-1:0] sched_dout = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_found;
   logic [AB-1:0] resp_acc_id;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   // Contents of the table as written by the "parser".
   logic [TT-1:0] tab_type  [16];
   logic [AB-1:0] tab_first [16];
   logic [AB-1:0] tab_cnt   [16];

   // Transaction-level model state.
   bit busy = 1'b0;
   int resp_cyc = 0;
   bit exp_found = 1'b0;
   int exp_id = 0;
   int exp_reads = 0;
   int rr_m [16];
   int rd_log [$];

   sched_acc_select dut (
      .clk           (clk),
      .rstn          (rstn),
      .table_valid   (table_valid),
      .num_acc_types (num_acc_types),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_task_type (req_task_type),
      .sched_addr    (sched_addr),
      .sched_en      (sched_en),
      .sched_dout    (sched_dout),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_found    (resp_found),
      .resp_acc_id   (resp_acc_id)
   );

   // Free-running clock.
   initial begin
      forever #5 clk = ~clk;
   end

   // Cycle counter and the table RAM's read port, which returns data the
   // cycle after the enable.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sched_en) begin
         sched_dout <= {tab_first[sched_addr], tab_cnt[sched_addr], tab_type[sched_addr]};
      end
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, required finish before 500000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: got timeout, required handshake within bound", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called when a request is accepted: search the table, pick the
   // instance, advance the round-robin counter and work out the cycle on
   // which the answer must first appear.
   task automatic predict(input logic [TT-1:0] t);
      int k;
      int num;
      k = -1;
      num = int'(num_acc_types);
      for (int i = 0; i < num; i++) begin
         if (k < 0 && tab_type[i] == t) k = i;
      end
      busy = 1'b1;
      rd_log.delete();
      if (num == 0) begin
         exp_found = 1'b0;
         exp_id    = 0;
         exp_reads = 0;
         resp_cyc  = cyc + 1;
      end else if (k < 0) begin
         exp_found = 1'b0;
         exp_id    = 0;
         exp_reads = num;
         resp_cyc  = cyc + 1 + 2 * num;
      end else begin
         exp_found = 1'b1;
         exp_id    = (int'(tab_first[k]) + rr_m[k]) % 16;
         rr_m[k]   = (rr_m[k] == int'(tab_cnt[k])) ? 0 : (rr_m[k] + 1) % 16;
         exp_reads = k + 1;
         resp_cyc  = cyc + 3 + 2 * k;
      end
   endtask

   // The single compare process. It checks the outputs against the
   // model's view of the current cycle and then advances the model by
   // the events that the next rising edge will commit. Inputs change only
   // just after a rising edge, so what is seen here holds through that edge.
   always @(negedge clk) begin
      if (check_en) begin
         if (!busy) begin
            checkOutput("idle_req_ready", req_ready, table_valid);
            checkOutput("idle_resp_valid", resp_valid, 0);
            checkOutput("idle_sched_en", sched_en, 0);
         end else if (cyc < resp_cyc) begin
            checkOutput("busy_req_ready", req_ready, 0);
            checkOutput("early_resp_valid", resp_valid, 0);
            if (sched_en === 1'b1) rd_log.push_back(int'(sched_addr));
         end else begin
            checkOutput("resp_valid", resp_valid, 1);
            checkOutput("resp_req_ready", req_ready, 0);
            checkOutput("resp_sched_en", sched_en, 0);
            checkOutput("resp_found", resp_found, exp_found);
            checkOutput("resp_acc_id", resp_acc_id, exp_id);
            if (cyc == resp_cyc) begin
               checkOutput("read_count", rd_log.size(), exp_reads);
               for (int i = 0; i < rd_log.size(); i++) begin
                  checkOutput("read_addr", rd_log[i], i);
               end
            end
         end
      end

      if (!rstn) begin
         busy = 1'b0;
         rd_log.delete();
         for (int i = 0; i < 16; i++) rr_m[i] = 0;
      end else begin
         if (!table_valid) begin
            for (int i = 0; i < 16; i++) rr_m[i] = 0;
         end
         if (busy && cyc >= resp_cyc && resp_ready) begin
            busy = 1'b0;
         end else if (!busy && req_valid && table_valid) begin
            predict(req_task_type);
         end
      end
   end

   // One full request/response transaction; hold is the number of extra
   // cycles resp_ready stays low after the response appears.
   task automatic applyStimulus(input logic [TT-1:0] t, input int hold,
                                output logic f, output logic [AB-1:0] id, output int lat);
      int guard;
      guard = 0;
      f = 1'b0;
      id = '0;
      lat = -1;
      while (req_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      if (req_ready !== 1'b1) begin
         timeoutFail("req_ready_wait");
         return;
      end
      req_valid = 1'b1;
      req_task_type = t;
      tick();
      req_valid = 1'b0;
      req_task_type = {8'($urandom), $urandom};
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      if (resp_valid !== 1'b1) begin
         timeoutFail("resp_wait");
         return;
      end
      f = resp_found;
      id = resp_acc_id;
      repeat (hold) tick();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   // Rewrites the table with table_valid low, then reopens it.
   task automatic loadDirected();
      table_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tab_type[i]  = {8'hA5, $urandom};
         tab_first[i] = 4'($urandom_range(0, 15));
         tab_cnt[i]   = 4'($urandom_range(0, 3));
      end
      tab_type[0] = 40'h11; tab_first[0] = 4'd0; tab_cnt[0] = 4'd1;
      tab_type[1] = 40'h22; tab_first[1] = 4'd2; tab_cnt[1] = 4'd2;
      num_acc_types = 5'd2;
      tick();
      table_valid = 1'b1;
      tick();
   endtask

   logic          f;
   logic [AB-1:0] id;
   int            lat;
   logic [TT-1:0] pool [7];
   int            exp_ids [4] = '{2, 3, 4, 2};
   int            guard;

   // Main stimulus: reset, directed scenarios with literal expectations, then
   // randomised tables and requests checked purely by the model.
   initial begin
      for (int i = 0; i < 16; i++) begin
         tab_type[i] = '0; tab_first[i] = '0; tab_cnt[i] = '0; rr_m[i] = 0;
      end
      rstn = 1'b0;
      repeat (3) tick();
      checkOutput("reset_resp_valid", resp_valid, 0);
      checkOutput("reset_resp_found", resp_found, 0);
      checkOutput("reset_resp_acc_id", resp_acc_id, 0);
      checkOutput("reset_sched_en", sched_en, 0);
      checkOutput("reset_sched_addr", sched_addr, 0);
      checkOutput("reset_req_ready", req_ready, 0);
      rstn = 1'b1;
      check_en = 1'b1;
      tick();

      $display("[TB] directed: round robin over entry 1");
      loadDirected();
      for (int n = 0; n < 4; n++) begin
         applyStimulus(40'h22, 0, f, id, lat);
         checkOutput("rr_found", f, 1);
         checkOutput("rr_acc_id", id, exp_ids[n]);
         if (n == 0) checkOutput("hit_entry1_latency", lat, 5);
      end

      $display("[TB] directed: miss leaves round robin alone");
      applyStimulus(40'h33, 1, f, id, lat);
      checkOutput("miss_found", f, 0);
      checkOutput("miss_acc_id", id, 0);
      checkOutput("miss_latency", lat, 5);
      applyStimulus(40'h22, 0, f, id, lat);
      checkOutput("after_miss_acc_id", id, 3);

      $display("[TB] directed: response held for five cycles");
      applyStimulus(40'h11, 5, f, id, lat);
      checkOutput("hold_found", f, 1);
      checkOutput("hold_acc_id", id, 0);
      checkOutput("hit_entry0_latency", lat, 3);

      $display("[TB] directed: empty table");
      table_valid = 1'b0;
      num_acc_types = 5'd0;
      tick();
      table_valid = 1'b1;
      applyStimulus(40'h11, 0, f, id, lat);
      checkOutput("empty_found", f, 0);
      checkOutput("empty_latency", lat, 1);
      loadDirected();

      $display("[TB] directed: reset during lookup");
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
      req_valid = 1'b1;
      req_task_type = 40'h22;
      tick();
      req_valid = 1'b0;
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      repeat (6) tick();
      checkOutput("reset_drop_resp_valid", resp_valid, 0);
      applyStimulus(40'h22, 0, f, id, lat);
      checkOutput("post_reset_acc_id", id, 2);
      applyStimulus(40'h11, 0, f, id, lat);
      checkOutput("pre_clear_acc_id", id, 0);
      table_valid = 1'b0;
      tick();
      table_valid = 1'b1;
      tick();
      applyStimulus(40'h11, 0, f, id, lat);
      checkOutput("post_clear_acc_id", id, 0);

      $display("[TB] directed: table_valid drops mid-lookup");
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
      req_valid = 1'b1;
      req_task_type = 40'h33;
      tick();
      req_valid = 1'b0;
      table_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
      checkOutput("tv_drop_latency", lat, 5);
      checkOutput("tv_drop_found", resp_found, 0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      tick();
      table_valid = 1'b1;
      tick();

      $display("[TB] random tables and requests");
      for (int round = 0; round < 8; round++) begin
         table_valid = 1'b0;
         for (int i = 0; i < 6; i++) pool[i] = {8'($urandom), $urandom};
         pool[6] = pool[0];
         pool[6][39] = ~pool[0][39];
         num_acc_types = 5'($urandom_range(0, 16));
         for (int i = 0; i < 16; i++) begin
            tab_type[i]  = pool[$urandom_range(0, 5)];
            tab_first[i] = 4'($urandom_range(0, 15));
            tab_cnt[i]   = 4'($urandom_range(0, 3));
         end
         tick();
         table_valid = 1'b1;
         tick();
         for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 4) == 0) begin
               applyStimulus({8'($urandom), $urandom}, $urandom_range(0, 3), f, id, lat);
            end else begin
               applyStimulus(pool[$urandom_range(0, 6)], $urandom_range(0, 3), f, id, lat);
            end
            repeat ($urandom_range(0, 2)) tick();
         end
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
